// File: rtl/dispatch_pkg.sv
// Shared types for the dispatch stage: rename/dispatch payloads, functional-unit
// class and the opcode constants used to steer instructions to a station.
package dispatch_pkg;

    localparam int DEF_NUM_PREG = 128;
    localparam int DEF_PREG_W   = 8;
    localparam int DEF_ROB_W    = 4;
    localparam int IMM_W        = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_BRU = 2'd2
    } fu_class_t;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [DEF_PREG_W-1:0] ps1;
        logic [DEF_PREG_W-1:0] ps2;
        logic [DEF_PREG_W-1:0] pd_new;
        logic [DEF_PREG_W-1:0] pd_old;
        logic [IMM_W-1:0]      imm;
    } rename_data;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [DEF_PREG_W-1:0] ps1;
        logic                  ps1_rdy;
        logic [DEF_PREG_W-1:0] ps2;
        logic                  ps2_rdy;
        logic [DEF_PREG_W-1:0] pd_new;
        logic [IMM_W-1:0]      imm;
        logic [DEF_ROB_W-1:0]  rob_tag;
    } dispatch_data;

    function automatic fu_class_t decode_class(input logic [6:0] op);
        fu_class_t c;
        case (op)
            OP_LOAD, OP_STORE:          c = FU_LSU;
            OP_BRANCH, OP_JAL, OP_JALR: c = FU_BRU;
            default:                    c = FU_ALU;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dispatch_busy_table.sv
// Physical-register busy bits: one set port (dispatch), one clear port (CDB) and
// two combinational read ports. Tag 0 is hard-wired ready.
module dispatch_busy_table #(
    parameter int NUM_PREG = 128,
    parameter int PREG_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en_i,
    input  logic [PREG_W-1:0] set_tag_i,
    input  logic              clr_en_i,
    input  logic [PREG_W-1:0] clr_tag_i,
    input  logic [PREG_W-1:0] rd0_tag_i,
    output logic              rd0_busy_o,
    input  logic [PREG_W-1:0] rd1_tag_i,
    output logic              rd1_busy_o
);

    logic [NUM_PREG-1:0] busy_q;
    logic [NUM_PREG-1:0] busy_d;
    logic [NUM_PREG-1:0] rd0_hit;
    logic [NUM_PREG-1:0] rd1_hit;

    // Per-bit update; a set wins over a clear to the same tag in the same cycle.
    generate
        for (genvar gi = 0; gi < NUM_PREG; gi++) begin : g_bit
            assign rd0_hit[gi] = (rd0_tag_i == PREG_W'(gi));
            assign rd1_hit[gi] = (rd1_tag_i == PREG_W'(gi));
            if (gi == 0) begin : g_p0
                assign busy_d[gi] = 1'b0;
            end else begin : g_pn
                always_comb begin
                    busy_d[gi] = busy_q[gi];
                    if (clr_en_i && clr_tag_i == PREG_W'(gi)) begin
                        busy_d[gi] = 1'b0;
                    end
                    if (set_en_i && set_tag_i == PREG_W'(gi)) begin
                        busy_d[gi] = 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd0_busy_o = |(busy_q & rd0_hit);
    assign rd1_busy_o = |(busy_q & rd1_hit);

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: single-entry pipeline slot after rename that tracks operand
// readiness, allocates a ROB entry and issues into the ALU/LSU/BRU station.
module dispatch
    import dispatch_pkg::*;
#(
    parameter int NUM_PREG = DEF_NUM_PREG,
    parameter int PREG_W   = DEF_PREG_W,
    parameter int ROB_W    = DEF_ROB_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  rename_data        data_in,
    output logic              ready_in,
    input  logic              mispredict,
    input  logic              cdb_valid,
    input  logic [PREG_W-1:0] cdb_tag,
    input  logic              rob_alloc_ready,
    input  logic [ROB_W-1:0]  rob_tag,
    output logic              rob_alloc_valid,
    output logic [PREG_W-1:0] rob_pd_new,
    output logic [PREG_W-1:0] rob_pd_old,
    output logic              alu_rs_valid,
    output logic              lsu_rs_valid,
    output logic              bru_rs_valid,
    input  logic              alu_rs_ready,
    input  logic              lsu_rs_ready,
    input  logic              bru_rs_ready,
    output dispatch_data      rs_data
);

    logic       slot_valid_q, slot_valid_d;
    rename_data slot_data_q, slot_data_d;
    fu_class_t  slot_class_q, slot_class_d;
    logic       ps1_rdy_q, ps1_rdy_d;
    logic       ps2_rdy_q, ps2_rdy_d;

    logic in_busy1, in_busy2;
    logic in_rdy1, in_rdy2;
    logic slot_rdy1, slot_rdy2;
    logic target_ready;
    logic offer;
    logic fire;
    logic accept;
    logic dest_set;

    dispatch_busy_table #(
        .NUM_PREG (NUM_PREG),
        .PREG_W   (PREG_W)
    ) u_busy (
        .clk        (clk),
        .reset      (reset),
        .set_en_i   (dest_set),
        .set_tag_i  (slot_data_q.pd_new),
        .clr_en_i   (cdb_valid),
        .clr_tag_i  (cdb_tag),
        .rd0_tag_i  (data_in.ps1),
        .rd0_busy_o (in_busy1),
        .rd1_tag_i  (data_in.ps2),
        .rd1_busy_o (in_busy2)
    );

    always_comb begin
        target_ready = alu_rs_ready;
        case (slot_class_q)
            FU_LSU:  target_ready = lsu_rs_ready;
            FU_BRU:  target_ready = bru_rs_ready;
            default: target_ready = alu_rs_ready;
        endcase
    end

    assign offer    = slot_valid_q && rob_alloc_ready && !mispredict;
    assign fire     = offer && target_ready;
    assign dest_set = fire && (slot_data_q.pd_new != '0);
    assign ready_in = !mispredict && (!slot_valid_q || fire);
    assign accept   = valid_in && ready_in;

    // The busy bit for a producer firing this cycle only lands at the edge, so a
    // consumer captured on that same edge has to see the pending write here.
    assign in_rdy1 = (cdb_valid && cdb_tag == data_in.ps1) ||
                     !(in_busy1 || (dest_set && slot_data_q.pd_new == data_in.ps1));
    assign in_rdy2 = (cdb_valid && cdb_tag == data_in.ps2) ||
                     !(in_busy2 || (dest_set && slot_data_q.pd_new == data_in.ps2));

    assign slot_rdy1 = ps1_rdy_q || (cdb_valid && cdb_tag == slot_data_q.ps1);
    assign slot_rdy2 = ps2_rdy_q || (cdb_valid && cdb_tag == slot_data_q.ps2);

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        slot_class_d = slot_class_q;
        ps1_rdy_d    = slot_rdy1;
        ps2_rdy_d    = slot_rdy2;
        if (mispredict) begin
            slot_valid_d = 1'b0;
        end else if (accept) begin
            slot_valid_d = 1'b1;
            slot_data_d  = data_in;
            slot_class_d = decode_class(data_in.opcode);
            ps1_rdy_d    = in_rdy1;
            ps2_rdy_d    = in_rdy2;
        end else if (fire) begin
            slot_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_q <= 1'b0;
            slot_data_q  <= '0;
            slot_class_q <= FU_ALU;
            ps1_rdy_q    <= 1'b0;
            ps2_rdy_q    <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            slot_class_q <= slot_class_d;
            ps1_rdy_q    <= ps1_rdy_d;
            ps2_rdy_q    <= ps2_rdy_d;
        end
    end

    assign alu_rs_valid    = offer && (slot_class_q == FU_ALU);
    assign lsu_rs_valid    = offer && (slot_class_q == FU_LSU);
    assign bru_rs_valid    = offer && (slot_class_q == FU_BRU);
    assign rob_alloc_valid = fire;
    assign rob_pd_new      = slot_data_q.pd_new;
    assign rob_pd_old      = slot_data_q.pd_old;

    always_comb begin
        rs_data         = '0;
        rs_data.opcode  = slot_data_q.opcode;
        rs_data.ps1     = slot_data_q.ps1;
        rs_data.ps1_rdy = slot_rdy1;
        rs_data.ps2     = slot_data_q.ps2;
        rs_data.ps2_rdy = slot_rdy2;
        rs_data.pd_new  = slot_data_q.pd_new;
        rs_data.imm     = slot_data_q.imm;
        rs_data.rob_tag = rob_tag;
    end

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for dispatch: a table of class/handshake vectors plus hand-built
// sequences for dependency tracking, stalls, mispredict and reset corner cases.
module tb_dispatch;
    import dispatch_pkg::*;

    logic         clk;
    logic         reset;
    logic         valid_in;
    rename_data   data_in;
    logic         ready_in;
    logic         mispredict;
    logic         cdb_valid;
    logic [7:0]   cdb_tag;
    logic         rob_alloc_ready;
    logic [3:0]   rob_tag;
    logic         rob_alloc_valid;
    logic [7:0]   rob_pd_new;
    logic [7:0]   rob_pd_old;
    logic         alu_rs_valid, lsu_rs_valid, bru_rs_valid;
    logic         alu_rs_ready, lsu_rs_ready, bru_rs_ready;
    dispatch_data rs_data;

    int n_checks = 0;
    int n_errors = 0;

    dispatch dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .ready_in        (ready_in),
        .mispredict      (mispredict),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .rob_alloc_ready (rob_alloc_ready),
        .rob_tag         (rob_tag),
        .rob_alloc_valid (rob_alloc_valid),
        .rob_pd_new      (rob_pd_new),
        .rob_pd_old      (rob_pd_old),
        .alu_rs_valid    (alu_rs_valid),
        .lsu_rs_valid    (lsu_rs_valid),
        .bru_rs_valid    (bru_rs_valid),
        .alu_rs_ready    (alu_rs_ready),
        .lsu_rs_ready    (lsu_rs_ready),
        .bru_rs_ready    (bru_rs_ready),
        .rs_data         (rs_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic       rob_rdy, alu_rdy, lsu_rdy, bru_rdy;
        logic       e_alu, e_lsu, e_bru, e_fire;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic defaults();
        valid_in        = 1'b0;
        data_in         = '0;
        mispredict      = 1'b0;
        cdb_valid       = 1'b0;
        cdb_tag         = '0;
        rob_alloc_ready = 1'b1;
        rob_tag         = '0;
        alu_rs_ready    = 1'b1;
        lsu_rs_ready    = 1'b1;
        bru_rs_ready    = 1'b1;
    endtask

    task automatic send(input logic [6:0] op, input logic [7:0] ps1, input logic [7:0] ps2,
                        input logic [7:0] pd, input logic [7:0] pd_old, input logic [31:0] imm);
        valid_in       = 1'b1;
        data_in.opcode = op;
        data_in.ps1    = ps1;
        data_in.ps2    = ps2;
        data_in.pd_new = pd;
        data_in.pd_old = pd_old;
        data_in.imm    = imm;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{OP_OP,     1, 1, 1, 1, 1, 0, 0, 1};
        vecs[1] = '{OP_LOAD,   1, 1, 1, 1, 0, 1, 0, 1};
        vecs[2] = '{OP_STORE,  1, 1, 0, 1, 0, 1, 0, 0};
        vecs[3] = '{OP_BRANCH, 1, 1, 1, 1, 0, 0, 1, 1};
        vecs[4] = '{OP_JAL,    1, 1, 1, 0, 0, 0, 1, 0};
        vecs[5] = '{OP_JALR,   0, 1, 1, 1, 0, 0, 0, 0};
        vecs[6] = '{OP_LUI,    1, 0, 1, 1, 1, 0, 0, 0};
        vecs[7] = '{OP_OP,     1, 1, 0, 0, 1, 0, 0, 1};
        vecs[8] = '{OP_LOAD,   0, 1, 1, 1, 0, 0, 0, 0};
        vecs[9] = '{OP_OPIMM,  1, 1, 0, 0, 1, 0, 0, 1};

        defaults();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        step();
        reset = 1'b0;
        #1;
        check("reset_ready_in", 32'(ready_in), 1);
        check("reset_alu_v", 32'(alu_rs_valid), 0);
        check("reset_lsu_v", 32'(lsu_rs_valid), 0);
        check("reset_bru_v", 32'(bru_rs_valid), 0);
        check("reset_rob_v", 32'(rob_alloc_valid), 0);

        // Producer ADD p40 <- p5,p6 followed immediately by a consumer of p40.
        send(OP_OP, 8'd5, 8'd6, 8'd40, 8'd12, 32'd0);
        step();
        send(OP_OP, 8'd40, 8'd5, 8'd41, 8'd13, 32'd0);
        #1;
        check("add1_alu_v", 32'(alu_rs_valid), 1);
        check("add1_rob_v", 32'(rob_alloc_valid), 1);
        check("add1_ps1_rdy", 32'(rs_data.ps1_rdy), 1);
        check("add1_ps2_rdy", 32'(rs_data.ps2_rdy), 1);
        check("add1_pd_new", 32'(rob_pd_new), 40);
        check("add1_pd_old", 32'(rob_pd_old), 12);
        check("add1_ready_in", 32'(ready_in), 1);
        step();
        defaults();
        alu_rs_ready = 1'b0;
        #1;
        check("add2_alu_v", 32'(alu_rs_valid), 1);
        check("add2_ps1", 32'(rs_data.ps1), 40);
        check("add2_ps1_rdy", 32'(rs_data.ps1_rdy), 0);
        check("add2_ps2_rdy", 32'(rs_data.ps2_rdy), 1);
        check("add2_stall_rob_v", 32'(rob_alloc_valid), 0);
        check("add2_stall_ready_in", 32'(ready_in), 0);
        step();
        alu_rs_ready = 1'b1;
        cdb_valid    = 1'b1;
        cdb_tag      = 8'd40;
        #1;
        check("add2_cdb_ps1_rdy", 32'(rs_data.ps1_rdy), 1);
        check("add2_fire", 32'(rob_alloc_valid), 1);
        step();
        defaults();
        #1;
        check("add2_done_alu_v", 32'(alu_rs_valid), 0);
        check("add2_done_ready_in", 32'(ready_in), 1);

        // Store with no destination, held by lsu_rs_ready=0 for three cycles.
        send(OP_STORE, 8'd40, 8'd0, 8'd0, 8'd0, 32'd16);
        step();
        defaults();
        lsu_rs_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("st_stall%0d_lsu_v", i), 32'(lsu_rs_valid), 1);
            check($sformatf("st_stall%0d_ready_in", i), 32'(ready_in), 0);
            check($sformatf("st_stall%0d_rob_v", i), 32'(rob_alloc_valid), 0);
            check($sformatf("st_stall%0d_imm", i), rs_data.imm, 16);
            check($sformatf("st_stall%0d_ps1_rdy", i), 32'(rs_data.ps1_rdy), 1);
            step();
        end
        lsu_rs_ready = 1'b1;
        #1;
        check("st_fire", 32'(rob_alloc_valid), 1);
        check("st_ready_in", 32'(ready_in), 1);

        // Branch on busy p41, held by the ROB until a tag is free.
        step();
        defaults();
        send(OP_BRANCH, 8'd41, 8'd7, 8'd0, 8'd0, 32'h40);
        step();
        defaults();
        rob_alloc_ready = 1'b0;
        #1;
        check("br_norob_bru_v", 32'(bru_rs_valid), 0);
        check("br_norob_rob_v", 32'(rob_alloc_valid), 0);
        check("br_ps1_rdy", 32'(rs_data.ps1_rdy), 0);
        step();
        rob_alloc_ready = 1'b1;
        rob_tag         = 4'd7;
        #1;
        check("br_bru_v", 32'(bru_rs_valid), 1);
        check("br_fire", 32'(rob_alloc_valid), 1);
        check("br_rob_tag", 32'(rs_data.rob_tag), 7);

        // Mispredict with a full slot and a new instruction on the input.
        step();
        defaults();
        send(OP_OP, 8'd1, 8'd2, 8'd50, 8'd0, 32'd0);
        step();
        defaults();
        alu_rs_ready = 1'b0;
        #1;
        check("mp_pre_alu_v", 32'(alu_rs_valid), 1);
        step();
        alu_rs_ready = 1'b1;
        mispredict   = 1'b1;
        send(OP_LOAD, 8'd1, 8'd2, 8'd51, 8'd0, 32'd0);
        #1;
        check("mp_ready_in", 32'(ready_in), 0);
        check("mp_alu_v", 32'(alu_rs_valid), 0);
        check("mp_rob_v", 32'(rob_alloc_valid), 0);
        step();
        defaults();
        #1;
        check("mp_after_alu_v", 32'(alu_rs_valid), 0);
        check("mp_after_lsu_v", 32'(lsu_rs_valid), 0);
        check("mp_after_ready_in", 32'(ready_in), 1);

        // p0 always ready; squashed p50/p51 never marked busy.
        cdb_valid = 1'b1;
        cdb_tag   = 8'd0;
        send(OP_OP, 8'd0, 8'd50, 8'd0, 8'd0, 32'd0);
        step();
        defaults();
        send(OP_OP, 8'd0, 8'd51, 8'd0, 8'd0, 32'd0);
        #1;
        check("p0_ps1_rdy", 32'(rs_data.ps1_rdy), 1);
        check("p50_ps2_rdy", 32'(rs_data.ps2_rdy), 1);
        check("p0_fire", 32'(rob_alloc_valid), 1);
        step();
        defaults();
        #1;
        check("p0b_ps1_rdy", 32'(rs_data.ps1_rdy), 1);
        check("p51_ps2_rdy", 32'(rs_data.ps2_rdy), 1);

        // Reset while stalled discards the slot and clears busy p41.
        step();
        defaults();
        send(OP_OP, 8'd3, 8'd4, 8'd60, 8'd0, 32'd0);
        step();
        defaults();
        alu_rs_ready = 1'b0;
        reset        = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("rst_stall_alu_v", 32'(alu_rs_valid), 0);
        check("rst_stall_ready_in", 32'(ready_in), 1);
        send(OP_OP, 8'd41, 8'd0, 8'd0, 8'd0, 32'd0);
        step();
        defaults();
        #1;
        check("rst_p41_rdy", 32'(rs_data.ps1_rdy), 1);
        step();

        // Table vectors: class steering and handshake.
        for (int i = 0; i < 10; i++) begin
            defaults();
            send(vecs[i].op, 8'd1, 8'd2, 8'(70 + i), 8'd0, 32'(i));
            step();
            defaults();
            rob_alloc_ready = vecs[i].rob_rdy;
            alu_rs_ready    = vecs[i].alu_rdy;
            lsu_rs_ready    = vecs[i].lsu_rdy;
            bru_rs_ready    = vecs[i].bru_rdy;
            #1;
            check($sformatf("v%0d_alu_v", i), 32'(alu_rs_valid), 32'(vecs[i].e_alu));
            check($sformatf("v%0d_lsu_v", i), 32'(lsu_rs_valid), 32'(vecs[i].e_lsu));
            check($sformatf("v%0d_bru_v", i), 32'(bru_rs_valid), 32'(vecs[i].e_bru));
            check($sformatf("v%0d_rob_v", i), 32'(rob_alloc_valid), 32'(vecs[i].e_fire));
            check($sformatf("v%0d_ready_in", i), 32'(ready_in), 32'(vecs[i].e_fire));
            check($sformatf("v%0d_opcode", i), 32'(rs_data.opcode), 32'(vecs[i].op));
            $display("vector %0d op=%b alu=%b lsu=%b bru=%b rob=%b", i, vecs[i].op,
                     alu_rs_valid, lsu_rs_valid, bru_rs_valid, rob_alloc_valid);
            step();
            mispredict = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dispatch.md
# dispatch

Dispatch stage directly downstream of register rename. It takes one renamed instruction per cycle and holds it in a single output slot. While held, it looks up and snoops operand readiness in a physical-register busy table. It then allocates a ROB entry and issues the instruction into the ALU, LSU or branch reservation station selected by its opcode.

## Interface
- NUM_PREG, default 128: physical registers; busy table depth.
- PREG_W, default 8: physical tag width; matches rename_data pd/ps fields.
- ROB_W, default 4: ROB tag width.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  rename_data valid.
- data_in  input  rename_data  Opcode, ps1, ps2, pd_new, pd_old, imm from rename.
- ready_in  output  1  dispatch can accept data_in this cycle.
- mispredict  input  1  flush from ROB.
- cdb_valid  input  1  writeback broadcast valid.
- cdb_tag  input  PREG_W  physical register being written back.
- rob_alloc_ready  input  1  ROB has a free entry.
- rob_tag  input  ROB_W  tag of next ROB entry (combinational from ROB tail).
- rob_alloc_valid  output  1  allocate ROB entry this cycle.
- rob_pd_new, rob_pd_old  output  PREG_W each  sent to ROB with the allocation.
- alu_rs_valid, lsu_rs_valid, bru_rs_valid  output  1 each  issue to that reservation station.
- alu_rs_ready, lsu_rs_ready, bru_rs_ready  input  1 each  station has a free entry.
- rs_data  output  dispatch_data  shared payload to all stations.

## Operation
- Class decode from Opcode. LSU: 0000011, 0100011. BRU: 1100011, 1101111, 1100111. ALU: everything else.
- Busy table: NUM_PREG bits, 1 means result pending. p0 always reads ready and is never set.
- Capture: on valid_in && ready_in, the slot loads data_in, class and rob-independent fields.
- ps1_rdy and ps2_rdy at capture = !busy[ps] || (cdb_valid && cdb_tag == ps).
- While held, each ready bit also sets when cdb_valid && cdb_tag matches; ready bits never clear.
- Target ready = the class's *_rs_ready.
- fire = slot_valid && rob_alloc_ready && target ready && !mispredict.
- *_rs_valid = slot_valid && class match && rob_alloc_ready && !mispredict.
- rob_alloc_valid = fire.
- rs_data carries opcode, ps1, ps1_rdy, ps2, ps2_rdy, pd_new, imm and rob_tag.
- On fire with pd_new != 0, busy[pd_new] is set next cycle.
- A cdb clear and a dispatch set to the same tag in the same cycle resolve to set.
- ready_in = !mispredict && (!slot_valid || fire); the slot is a full-throughput pipeline register.
- mispredict drops the slot (slot_valid <= 0), blocks capture and fire that cycle, and leaves the busy table unchanged.
- Stale busy bits on squashed tags are harmless: the tag is re-set when it is reallocated.

## Timing
- Reset: slot_valid 0; busy table all 0; every *_valid output 0; ready_in 1 on the first cycle after reset.
- Latency: an instruction accepted in cycle N is offered to a station in cycle N+1. Back-to-back accept and fire run one instruction per cycle.
- Outputs are combinational from the slot and the downstream readies; payload holds stable while stalled.
- Dependent back-to-back instructions: the producer fires in N. A consumer captured in N+1 sees busy=1 (set at the N edge), so ps_rdy=0 unless the CDB hits.
- Reset mid-stall discards the slot.
- Mispredict in the same cycle as valid_in: the input is not consumed.

## Structure
- types_pkg gains dispatch_data, fu_class_t (ALU/LSU/BRU), and opcode localparams shared with rename.
- One natural sub-module: busy_table, holding NUM_PREG bits with set port, clear port and two combinational read ports.

## Test plan
- Reset, then an ADD with ps1=5, ps2=6, pd_new=40 -> alu_rs_valid in the cycle after accept; ps1_rdy=ps2_rdy=1; busy[40]=1 after fire.
- Second ADD reading ps1=40 captured in the next cycle -> ps1_rdy=0. cdb_valid with cdb_tag=40 two cycles later -> ps1_rdy=1 in the same cycle; fire carries rdy=1.
- Store (0100011) with pd_new=0 -> lsu_rs_valid; busy table unchanged. With lsu_rs_ready=0 for 3 cycles: ready_in=0, payload stable, rob_alloc_valid=0.
- Branch with rob_alloc_ready=0 -> no *_rs_valid. rob_alloc_ready rises -> fire with rob_tag=7 in rs_data.
- Slot full and mispredict=1 with valid_in=1 -> slot empty next cycle; input not consumed; no rob_alloc_valid.
- cdb_tag=0 broadcast and an instruction with ps=0 -> always ready; busy[0] never set.
